pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4; register address width.
REQ-002 SHALL have parameter DEPTH, default 3; number of tracked in-flight stages after decode (DEPTH >= 2).
REQ-003 SHALL have parameter NSRC, default 2; number of decode source operands.
REQ-004 SHALL use one clock and a synchronous, active-high reset, named clk and rst respectively.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  decode slot holds a real instruction.
REQ-008 id_src  in  NSRC*REG_AW  source register addresses; operand i is at bits [i*REG_AW +: REG_AW].
REQ-009 id_src_used  in  NSRC  per-source read-enable.
REQ-010 id_dst  in  REG_AW  destination register.
REQ-011 id_wr  in  1  instruction writes the register file.
REQ-012 id_load  in  1  instruction is a memory load.
REQ-013 id_branch_reg  in  1  instruction resolves in decode using a source register (BR-type).
REQ-014 id_hlt  in  1  instruction is HLT.
REQ-015 branch_taken  in  1  redirect resolved this cycle.
REQ-016 stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
REQ-017 flush  out  1  clear IF/ID.
REQ-018 fwd_sel  out  NSRC*2  per-source select: 0 = register file, 1 = stage 1 (EX output), 2 = stage 2 (MEM output), 3 = reserved.
REQ-019 halted  out  1  pipeline fully drained after HLT.

Function
REQ-020 SHALL keep a DEPTH-entry scoreboard shift register; entry k = {valid, wr, load, dst} of the instruction k+1 stages past decode.
REQ-021 On each non-reset edge, entries SHALL shift by one; entry 0 SHALL load decode fields when id_valid && !stall && !flush, otherwise a bubble (valid=0).
REQ-022 A hazard match for source i SHALL require id_valid, id_src_used[i], entry valid, entry wr, entry dst == src, and src != 0.
REQ-023 Load-use: stall SHALL be 1 when any source matches entry 0 with load=1.
REQ-024 Branch hazard: stall SHALL be 1 when id_branch_reg and the source matches entry 0 (any write), or matches entry 1 with load=1.
REQ-025 fwd_sel[i] SHALL be 1 if source i matches entry 0, else 2 if it matches entry 1, else 0; the youngest match SHALL win.
REQ-026 stall, flush and fwd_sel SHALL be combinational from the inputs and the scoreboard (zero-cycle latency).
REQ-027 flush SHALL equal branch_taken && !stall; when branch_taken and stall are both 1, stall SHALL win and flush SHALL be 0.
REQ-028 FSM states: RUN, DRAIN, HALTED.
REQ-029 RUN -> DRAIN when id_valid && id_hlt && !stall && !flush; the HLT entry SHALL enter the scoreboard.
REQ-030 In DRAIN, a counter SHALL count DEPTH cycles; stall SHALL be held at 1 and entry 0 SHALL receive bubbles; DRAIN -> HALTED when the count reaches DEPTH.
REQ-031 HALTED SHALL be terminal until rst; halted = 1 only in HALTED; stall SHALL be held at 1.
REQ-032 An HLT that arrives while flush = 1 SHALL be discarded, with no state change.

Reset
REQ-033 On rst = 1 at a clock edge: all scoreboard entries SHALL become invalid, state SHALL become RUN, and the drain counter SHALL become 0.
REQ-034 After reset, stall = 0, flush = branch_taken, fwd_sel = 0 and halted = 0.
REQ-035 rst SHALL take priority over every other input, including mid-DRAIN and in HALTED.

Configuration
REQ-036 SHALL use the macro HAZARD_FWD_EN.
REQ-037 When HAZARD_FWD_EN is defined, behaviour SHALL be as in REQ-023 to REQ-025.
REQ-038 When HAZARD_FWD_EN is undefined, fwd_sel SHALL be tied to 0, and stall SHALL assert on any source matching any valid writing entry 0..DEPTH-2, regardless of load.

Verification
REQ-039 Load r3, then ADD using r3 -> stall=1 for exactly 1 cycle, then fwd_sel[0]=2 on the released cycle.
REQ-040 ADD r3, then SUB using r3 twice (sources 0 and 1) -> stall=0, fwd_sel=4'b0101; with HAZARD_FWD_EN undefined -> stall=1 for 2 cycles and fwd_sel=0.
REQ-041 ADD r0 as destination, then use of r0 -> stall=0, fwd_sel=0.
REQ-042 ADD r5, then BR using r5 with branch_taken=1 -> first cycle: stall=1, flush=0; next cycle: stall=0, flush=1.
REQ-043 HLT with DEPTH=3 -> stall=1 from the following cycle; halted=1 exactly 3 cycles after DRAIN entry; halted remains 1 until rst.
REQ-044 rst asserted on the 2nd DRAIN cycle -> next cycle: halted=0, stall=0, all entries invalid.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: scoreboard of in-flight writers, load-use/branch stalls,
// forwarding selects and HLT drain FSM. Define HAZARD_FWD_EN to enable operand forwarding.

module phc_src_match #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3
) (
    input  logic                      id_valid,
    input  logic                      used,
    input  logic [REG_AW-1:0]         src,
    input  logic [DEPTH-1:0]          ent_valid,
    input  logic [DEPTH-1:0]          ent_wr,
    input  logic [DEPTH*REG_AW-1:0]   ent_dst,
    output logic [DEPTH-1:0]          hit
);
    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            // r0 is hardwired zero, so a write to it never creates a dependency
            hit[k] = id_valid && used && (src != '0) && ent_valid[k] && ent_wr[k]
                     && (ent_dst[k*REG_AW +: REG_AW] == src);
        end
    end
endmodule

module pipeline_hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]      id_dst,
    input  logic                   id_wr,
    input  logic                   id_load,
    input  logic                   id_branch_reg,
    input  logic                   id_hlt,
    input  logic                   branch_taken,
    output logic                   stall,
    output logic                   flush,
    output logic [NSRC*2-1:0]      fwd_sel,
    output logic                   halted
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        wr_q, wr_d;
    logic [DEPTH-1:0]        load_q, load_d;
    logic [DEPTH*REG_AW-1:0] dst_q, dst_d;

    logic [NSRC-1:0][DEPTH-1:0] hit;
    logic [NSRC-1:0]            src_stall;
    logic                       haz_stall;
    logic                       push;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            phc_src_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match (
                .id_valid  (id_valid),
                .used      (id_src_used[i]),
                .src       (id_src[i*REG_AW +: REG_AW]),
                .ent_valid (valid_q),
                .ent_wr    (wr_q),
                .ent_dst   (dst_q),
                .hit       (hit[i])
            );
`ifdef HAZARD_FWD_EN
            // BR resolves in decode, so even an EX result is too late; a load in MEM is too
            assign src_stall[i] = (hit[i][0] && load_q[0])
                               || (id_branch_reg && (hit[i][0] || (hit[i][1] && load_q[1])));
            assign fwd_sel[i*2 +: 2] = hit[i][0] ? 2'd1 : (hit[i][1] ? 2'd2 : 2'd0);
`else
            assign src_stall[i] = |hit[i][DEPTH-2:0];
            assign fwd_sel[i*2 +: 2] = 2'd0;
`endif
        end
    endgenerate

    assign haz_stall = |src_stall;
    assign stall     = haz_stall || (state_q != RUN);
    assign flush     = branch_taken && !stall;
    assign halted    = (state_q == HALTED);
    assign push      = id_valid && !stall && !flush;

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], push};
        wr_d    = {wr_q[DEPTH-2:0], id_wr};
        load_d  = {load_q[DEPTH-2:0], id_load};
        dst_d   = {dst_q[(DEPTH-1)*REG_AW-1:0], id_dst};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (id_valid && id_hlt && !stall && !flush) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(DEPTH)) state_d = HALTED;
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            valid_q <= '0;
            wr_q    <= '0;
            load_q  <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            dst_q   <= dst_d;
        end
    end

    // Oldest entry and, without forwarding, the load/branch qualifiers are never inspected
    logic unused_sb;
    assign unused_sb = ^{id_load, id_branch_reg, valid_q, wr_q, load_q, dst_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.

module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic [3:0] id_dst;
    logic       id_wr, id_load, id_branch_reg, id_hlt, branch_taken;
    logic       stall, flush, halted;
    logic [3:0] fwd_sel;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .NSRC(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_src        (id_src),
        .id_src_used   (id_src_used),
        .id_dst        (id_dst),
        .id_wr         (id_wr),
        .id_load       (id_load),
        .id_branch_reg (id_branch_reg),
        .id_hlt        (id_hlt),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .flush         (flush),
        .fwd_sel       (fwd_sel),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic drv(input bit v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] u, input logic [3:0] d, input bit w,
                       input bit ld, input bit br, input bit h, input bit bt);
        id_valid      = v;
        id_src        = {s1, s0};
        id_src_used   = u;
        id_dst        = d;
        id_wr         = w;
        id_load       = ld;
        id_branch_reg = br;
        id_hlt        = h;
        branch_taken  = bt;
    endtask

    task automatic idle();
        drv(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle();
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL reset_fwd: got %b want 0000", fwd_sel); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        step();
        drv(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL reset_flush_bt: got %b want 1", flush); end
        step();
        // a load pushed on a reset edge must not survive
        drv(1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 1, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv(1, 4'd3, 4'd0, 2'b01, 4'd4, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_priority_stall: got %b want 0", stall); end
        settle();
    endtask

    task automatic test_load_use();
        int n;
        drv(1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_first: got %b want 0", stall); end
        step();
        drv(1, 4'd3, 4'd0, 2'b01, 4'd4, 1, 0, 0, 0, 0);
        n = 0;
        @(negedge clk);
        while (stall && n < 10) begin n++; @(negedge clk); end
        checks++; if (n != (FWD ? 1 : 2)) begin errors++; $display("FAIL lu_stall_cycles: got %0d want %0d", n, FWD ? 1 : 2); end
        checks++; if (fwd_sel !== (FWD ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL lu_fwd: got %b want %b", fwd_sel, FWD ? 4'b0010 : 4'b0000); end
        settle();
    endtask

    task automatic test_fwd_both();
        int n;
        drv(1, 4'd0, 4'd0, 2'b00, 4'd3, 1, 0, 0, 0, 0);
        step();
        drv(1, 4'd3, 4'd3, 2'b11, 4'd7, 1, 0, 0, 0, 0);
        n = 0;
        @(negedge clk);
        while (stall && n < 10) begin n++; @(negedge clk); end
        checks++; if (n != (FWD ? 0 : 2)) begin errors++; $display("FAIL ex_stall_cycles: got %0d want %0d", n, FWD ? 0 : 2); end
        checks++; if (fwd_sel !== (FWD ? 4'b0101 : 4'b0000)) begin errors++; $display("FAIL ex_fwd: got %b want %b", fwd_sel, FWD ? 4'b0101 : 4'b0000); end
        settle();
    endtask

    task automatic test_youngest();
        int n;
        drv(1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0, 0, 0, 0);
        step();
        drv(1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0, 0, 0, 0);
        step();
        drv(1, 4'd1, 4'd6, 2'b10, 4'd8, 1, 0, 0, 0, 0);
        n = 0;
        @(negedge clk);
        while (stall && n < 10) begin n++; @(negedge clk); end
        checks++; if (n != (FWD ? 0 : 2)) begin errors++; $display("FAIL young_stall_cycles: got %0d want %0d", n, FWD ? 0 : 2); end
        checks++; if (fwd_sel !== (FWD ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL young_fwd: got %b want %b", fwd_sel, FWD ? 4'b0100 : 4'b0000); end
        settle();
    endtask

    task automatic test_r0();
        drv(1, 4'd0, 4'd0, 2'b00, 4'd0, 1, 1, 0, 0, 0);
        step();
        drv(1, 4'd0, 4'd0, 2'b11, 4'd2, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", stall); end
        checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL r0_fwd: got %b want 0000", fwd_sel); end
        settle();
    endtask

    task automatic test_branch();
        int n;
        drv(1, 4'd0, 4'd0, 2'b00, 4'd5, 1, 0, 0, 0, 0);
        step();
        drv(1, 4'd5, 4'd0, 2'b01, 4'd0, 0, 0, 1, 0, 1);
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_first_stall: got %b want 1", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_first_flush: got %b want 0", flush); end
        n = 0;
        while (stall && n < 10) begin n++; @(negedge clk); end
        checks++; if (n != (FWD ? 1 : 2)) begin errors++; $display("FAIL br_stall_cycles: got %0d want %0d", n, FWD ? 1 : 2); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_release_flush: got %b want 1", flush); end
        settle();
    endtask

    task automatic test_hlt_flush();
        drv(1, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL hltfl_flush: got %b want 1", flush); end
        step();
        idle();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hltfl_stall: got %b want 0", stall); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hltfl_halted: got %b want 0", halted); end
        settle();
    endtask

    task automatic test_hlt();
        drv(1, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hlt_issue_stall: got %b want 0", stall); end
        step();
        idle();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hlt_stall_c%0d: got %b want 1", c, stall); end
            checks++; if (halted !== (c >= 4)) begin errors++; $display("FAIL hlt_halted_c%0d: got %b want %b", c, halted, c >= 4); end
            step();
        end
        drv(1, 4'd0, 4'd0, 2'b00, 4'd1, 1, 0, 0, 0, 1);
        repeat (5) step();
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_sticky: got %b want 1", halted); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL hlt_flush: got %b want 0", flush); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_reset_halted: got %b want 0", halted); end
        settle();
    endtask

    task automatic test_reset_drain();
        drv(1, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0, 1, 0);
        step();
        idle();
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd_drain_stall: got %b want 1", stall); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rd_halted: got %b want 0", halted); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_stall: got %b want 0", stall); end
        repeat (4) step();
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rd_no_rehalt: got %b want 0", halted); end
        settle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_both();
        test_youngest();
        test_r0();
        test_branch();
        test_hlt_flush();
        test_hlt();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
